// File: rtl/nand_seq_alu_pkg.sv
// Shared types and helpers for the bit-serial NAND sequencer.
package nand_seq_pkg;

  typedef enum logic [2:0] {
    NAND = 3'd0,
    NOT  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // NAND evaluations needed per result bit; reserved opcodes take one step.
  function automatic logic [2:0] op_steps(op_e op);
    case (op)
      NAND, NOT: return 3'd1;
      AND:       return 3'd2;
      OR:        return 3'd3;
      XOR:       return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  // Opcodes 5..7 are reserved.
  function automatic logic op_reserved(logic [2:0] op);
    return (op > 3'd4);
  endfunction

endpackage

// File: rtl/nand_seq_alu_gate.sv
// Single two-input NAND gate primitive.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = ~(a & b);

endmodule

// File: rtl/nand_seq_alu.sv
// Bit-serial word logic unit built from one time-shared NAND gate.
module nand_seq_alu
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             t1;
  logic             t2;
  logic             t3;
  logic [1:0]       step;
  logic [BW-1:0]    bitcnt;

  logic             ga;
  logic             gb;
  logic             g;
  logic [1:0]       last_step;
  logic             bit_last;
  logic             bit_in;

  nand_gate u_gate (
    .a   (ga),
    .b   (gb),
    .out (g)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign last_step = 2'(op_steps(op_r) - 3'd1);
  assign bit_last  = (step == last_step);
  // Reserved opcodes discard the gate result.
  assign bit_in    = out_err ? 1'b0 : g;

  // Route shift-register LSBs and temps to the gate for the current step.
  always_comb begin
    ga = 1'b0;
    gb = 1'b0;
    if (state == RUN) begin
      case (op_r)
        NAND: begin ga = a_sr[0]; gb = b_sr[0]; end
        NOT:  begin ga = a_sr[0]; gb = a_sr[0]; end
        AND: begin
          case (step)
            2'd0:    begin ga = a_sr[0]; gb = b_sr[0]; end
            default: begin ga = t1;      gb = t1;      end
          endcase
        end
        OR: begin
          case (step)
            2'd0:    begin ga = a_sr[0]; gb = a_sr[0]; end
            2'd1:    begin ga = b_sr[0]; gb = b_sr[0]; end
            default: begin ga = t1;      gb = t2;      end
          endcase
        end
        XOR: begin
          case (step)
            2'd0:    begin ga = a_sr[0]; gb = b_sr[0]; end
            2'd1:    begin ga = a_sr[0]; gb = t1;      end
            2'd2:    begin ga = b_sr[0]; gb = t1;      end
            default: begin ga = t2;      gb = t3;      end
          endcase
        end
        default: begin ga = a_sr[0]; gb = b_sr[0]; end
      endcase
    end
  end

  // Sequencer: accept, step through NAND evaluations per bit, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_r       <= NAND;
      a_sr       <= '0;
      b_sr       <= '0;
      t1         <= 1'b0;
      t2         <= 1'b0;
      t3         <= 1'b0;
      step       <= '0;
      bitcnt     <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr       <= in_a;
            b_sr       <= in_b;
            op_r       <= op_e'(in_op);
            out_err    <= op_reserved(in_op);
            out_result <= '0;
            step       <= '0;
            bitcnt     <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          // Temps are indexed by step; a write on a bit's final step is never read.
          case (step)
            2'd0:    t1 <= g;
            2'd1:    t2 <= g;
            2'd2:    t3 <= g;
            default: ;
          endcase
          if (bit_last) begin
            out_result <= {bit_in, out_result[WIDTH-1:1]};
            a_sr       <= a_sr >> 1;
            b_sr       <= b_sr >> 1;
            step       <= '0;
            bitcnt     <= bitcnt + 1'b1;
            if (bitcnt == BW'(WIDTH - 1))
              state <= DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_seq_alu.sv
// Scoreboard bench for nand_seq_alu.
module tb_nand_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_err;
  logic         busy;

  nand_seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return ~a;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic int unsigned steps(input logic [2:0] op);
    case (op)
      3'd2:    return 2;
      3'd3:    return 3;
      3'd4:    return 4;
      default: return 1;
    endcase
  endfunction

  // Wait for in_ready, present one request, then scramble inputs after accept.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input bit push, output int unsigned acc);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) q.push_back('{exp, (op > 3'd4), W * steps(op), cyc});
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !in_ready) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Output side: latency on rise, result/err on handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        check("latency", cyc - q[0].acc, q[0].lat);
        check("ready_low_in_done", {31'd0, in_ready}, 32'd0);
      end
    end
    if (out_valid && out_ready && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("result", {16'd0, out_result}, {16'd0, e.res});
      check("err", {31'd0, out_err}, {31'd0, e.err});
    end
    prev_v = out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned acc1, acc2;
    logic [W-1:0] ra, rb, rexp;
    logic [2:0]   rop;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", {16'd0, out_result}, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    rst = 1'b0;

    // AND and in_ready return one cycle after the handshake
    send(3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, acc1);
    wait_valid();
    @(negedge clk);
    check("and_ready_back", {31'd0, in_ready}, 32'd1);
    check("and_valid_gone", {31'd0, out_valid}, 32'd0);
    wait_drain();

    // XOR then OR back-to-back
    send(3'd4, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b1, acc1);
    send(3'd3, 16'hA000, 16'h0005, 16'hA005, 1'b1, acc2);
    check("min_spacing", {31'd0, (acc2 - acc1) >= 66}, 32'd1);
    wait_drain();

    // NAND then NOT
    send(3'd0, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b1, acc1);
    send(3'd1, 16'h0F0F, 16'h1234, 16'hF0F0, 1'b1, acc1);
    wait_drain();

    // Reserved opcode
    send(3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, acc1);
    wait_drain();

    // Backpressure with a pending request
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    ra = W'($urandom);
    rb = W'($urandom);
    send(3'd2, ra, rb, ra & rb, 1'b1, acc1);
    wait_valid();
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 16'h5A5A;
    in_b     = 16'h0FF0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", {16'd0, out_result}, {16'd0, ra & rb});
      check("bp_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_hs", {31'd0, in_ready}, 32'd1);
    check("bp_not_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    q.push_back('{16'hF5AF, 1'b0, W, cyc});
    check("bp_pending_taken", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of an XOR
    send(3'd4, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, acc1);
    while (cyc < acc1 + 19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", {16'd0, out_result}, 32'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    send(3'd2, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, acc1);
    wait_drain();

    // Random mix
    for (int i = 0; i < 8; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = W'($urandom);
      rb   = W'($urandom);
      rexp = model(rop, ra, rb);
      send(rop, ra, rb, rexp, 1'b1, acc1);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
